// File: rtl/idli_slice_alu.sv
// Slice-serial ALU and compare unit: operands stream LSB slice first, one
// registered result slice per cycle, compare/carry reported after the last slice.
module idli_slice_alu #(
  parameter int unsigned SLICE_W    = 4,
  parameter int unsigned NUM_SLICES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [1:0]         i_alu_op,
  input  logic               i_rhs_inv,
  input  logic [1:0]         i_cmp_op,
  input  logic               i_cmp_sign,
  input  logic [SLICE_W-1:0] i_lhs,
  input  logic [SLICE_W-1:0] i_rhs,
  output logic [SLICE_W-1:0] o_res,
  output logic               o_res_vld,
  output logic               o_busy,
  output logic               o_cout,
  output logic               o_cmp,
  output logic               o_cmp_vld
);

  localparam int unsigned CTR_W = (NUM_SLICES > 2) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;
  typedef enum logic [1:0] {CMP_EQ, CMP_NE, CMP_LT, CMP_GE}    cmp_op_t;
  typedef enum logic       {S_IDLE, S_RUN}                     state_t;

  state_t             state_q;
  logic [CTR_W-1:0]   ctr_q;
  logic               carry_q;
  logic               ccarry_q;
  logic               eq_q;
  alu_op_t            op_q;
  logic               inv_q;
  cmp_op_t            cmp_op_q;
  logic               sign_q;
  logic [SLICE_W-1:0] res_q;
  logic               res_vld_q;
  logic               cout_q;
  logic               cmp_q;
  logic               cmp_vld_q;

  logic               first;
  logic               active;
  logic               last;
  alu_op_t            op;
  logic               inv;
  cmp_op_t            cmp_op;
  logic               sign;
  logic [SLICE_W-1:0] rhs_eff;
  logic               cin;
  logic               ccin;
  logic               add_c;
  logic [SLICE_W-1:0] add_s;
  logic               sub_c;
  logic [SLICE_W-1:0] sub_s;
  logic [SLICE_W-1:0] res_d;
  logic               eq_d;
  logic               n_flag;
  logic               v_flag;
  logic               lt;
  logic               cmp_d;

  always_comb begin
    first   = (state_q == S_IDLE);
    active  = first ? i_start : 1'b1;
    last    = (state_q == S_RUN) && (ctr_q == CTR_W'(NUM_SLICES - 1));
    op      = first ? alu_op_t'(i_alu_op) : op_q;
    inv     = first ? i_rhs_inv : inv_q;
    cmp_op  = first ? cmp_op_t'(i_cmp_op) : cmp_op_q;
    sign    = first ? i_cmp_sign : sign_q;
    rhs_eff = inv ? ~i_rhs : i_rhs;
    cin     = first ? inv : carry_q;
    ccin    = first ? 1'b1 : ccarry_q;
    {add_c, add_s} = {1'b0, i_lhs} + {1'b0, rhs_eff} + {{SLICE_W{1'b0}}, cin};
    {sub_c, sub_s} = {1'b0, i_lhs} + {1'b0, ~i_rhs} + {{SLICE_W{1'b0}}, ccin};
    res_d = '0;
    case (op)
      ALU_ADD: res_d = add_s;
      ALU_AND: res_d = i_lhs & rhs_eff;
      ALU_OR:  res_d = i_lhs | rhs_eff;
      ALU_XOR: res_d = i_lhs ^ rhs_eff;
      default: res_d = '0;
    endcase
    // The chained difference is zero in every slice exactly when lhs == rhs.
    eq_d   = (first ? 1'b1 : eq_q) & (sub_s == '0);
    n_flag = sub_s[SLICE_W-1];
    v_flag = (i_lhs[SLICE_W-1] != i_rhs[SLICE_W-1]) && (sub_s[SLICE_W-1] != i_lhs[SLICE_W-1]);
    lt     = sign ? (n_flag ^ v_flag) : ~sub_c;
    cmp_d  = 1'b0;
    case (cmp_op)
      CMP_EQ:  cmp_d = eq_d;
      CMP_NE:  cmp_d = ~eq_d;
      CMP_LT:  cmp_d = lt;
      CMP_GE:  cmp_d = ~lt;
      default: cmp_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      ctr_q     <= '0;
      carry_q   <= 1'b0;
      ccarry_q  <= 1'b0;
      eq_q      <= 1'b1;
      op_q      <= ALU_ADD;
      inv_q     <= 1'b0;
      cmp_op_q  <= CMP_EQ;
      sign_q    <= 1'b0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      cout_q    <= 1'b0;
      cmp_q     <= 1'b0;
      cmp_vld_q <= 1'b0;
    end else begin
      res_vld_q <= active;
      cmp_vld_q <= last;
      if (active) begin
        res_q    <= res_d;
        carry_q  <= add_c;
        ccarry_q <= sub_c;
        eq_q     <= eq_d;
      end
      if (first) begin
        if (i_start) begin
          op_q     <= alu_op_t'(i_alu_op);
          inv_q    <= i_rhs_inv;
          cmp_op_q <= cmp_op_t'(i_cmp_op);
          sign_q   <= i_cmp_sign;
          ctr_q    <= CTR_W'(1);
          state_q  <= S_RUN;
        end
      end else if (last) begin
        state_q <= S_IDLE;
        ctr_q   <= '0;
        cmp_q   <= cmp_d;
        cout_q  <= (op == ALU_ADD) ? add_c : 1'b0;
      end else begin
        ctr_q <= ctr_q + CTR_W'(1);
      end
    end
  end

  assign o_res     = res_q;
  assign o_res_vld = res_vld_q;
  assign o_busy    = (state_q == S_RUN);
  assign o_cout    = cout_q;
  assign o_cmp     = cmp_q;
  assign o_cmp_vld = cmp_vld_q;

endmodule

// File: tb/tb_idli_slice_alu.sv
// Directed vector bench for idli_slice_alu (4x4 default plus an 8x4 instance).
module tb_idli_slice_alu;

  typedef struct {
    logic [1:0]  op;
    logic        inv;
    logic [1:0]  cmp;
    logic        sgn;
    logic [15:0] lhs;
    logic [15:0] rhs;
    logic [15:0] res;
    logic        cout;
    logic        cmpr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [1:0] i_alu_op = '0;
  logic       i_rhs_inv = 1'b0;
  logic [1:0] i_cmp_op = '0;
  logic       i_cmp_sign = 1'b0;
  logic [3:0] i_lhs = '0;
  logic [3:0] i_rhs = '0;
  logic [3:0] o_res;
  logic       o_res_vld, o_busy, o_cout, o_cmp, o_cmp_vld;

  logic       w_start = 1'b0;
  logic [7:0] w_lhs = '0;
  logic [7:0] w_rhs = '0;
  logic [7:0] w_res;
  logic       w_res_vld, w_busy, w_cout, w_cmp, w_cmp_vld;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  vec_t vt[14];

  always #5 clk = ~clk;

  idli_slice_alu dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_alu_op(i_alu_op),
    .i_rhs_inv(i_rhs_inv), .i_cmp_op(i_cmp_op), .i_cmp_sign(i_cmp_sign),
    .i_lhs(i_lhs), .i_rhs(i_rhs), .o_res(o_res), .o_res_vld(o_res_vld),
    .o_busy(o_busy), .o_cout(o_cout), .o_cmp(o_cmp), .o_cmp_vld(o_cmp_vld)
  );

  idli_slice_alu #(.SLICE_W(8), .NUM_SLICES(4)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(w_start), .i_alu_op(2'd0),
    .i_rhs_inv(1'b0), .i_cmp_op(2'd0), .i_cmp_sign(1'b0),
    .i_lhs(w_lhs), .i_rhs(w_rhs), .o_res(w_res), .o_res_vld(w_res_vld),
    .o_busy(w_busy), .o_cout(w_cout), .o_cmp(w_cmp), .o_cmp_vld(w_cmp_vld)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_vec(input int unsigned i, input logic [1:0] op, input logic inv,
                         input logic [1:0] cmp, input logic sgn, input logic [15:0] lhs,
                         input logic [15:0] rhs, input logic [15:0] res,
                         input logic cout, input logic cmpr);
    vt[i].op = op;   vt[i].inv = inv; vt[i].cmp = cmp;   vt[i].sgn = sgn;
    vt[i].lhs = lhs; vt[i].rhs = rhs; vt[i].res = res;   vt[i].cout = cout;
    vt[i].cmpr = cmpr;
  endtask

  // Checks the final slice and the completion pulse; caller is already at a negedge.
  task automatic end_op(input vec_t v);
    logic [15:0] r;
    r = v.res;
    chk("last_res", {28'd0, o_res}, {28'd0, r[15:12]});
    chk("last_vld", {31'd0, o_res_vld}, 32'd1);
    chk("cmp_vld", {31'd0, o_cmp_vld}, 32'd1);
    chk("cmp", {31'd0, o_cmp}, {31'd0, v.cmpr});
    chk("cout", {31'd0, o_cout}, {31'd0, v.cout});
    chk("busy_done", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic drive_op(input vec_t v, input bit has_prev, input vec_t pv, input bit noise);
    logic [15:0] r, l, h;
    r = v.res; l = v.lhs; h = v.rhs;
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0 && has_prev) end_op(pv);
      if (k > 0) begin
        chk("res", {28'd0, o_res}, {28'd0, r[(k-1)*4 +: 4]});
        chk("res_vld", {31'd0, o_res_vld}, 32'd1);
        chk("cmp_vld_mid", {31'd0, o_cmp_vld}, 32'd0);
        chk("busy", {31'd0, o_busy}, 32'd1);
      end
      i_start = (k == 0) || (noise && k == 2);
      if (k == 0) begin
        i_alu_op = v.op; i_rhs_inv = v.inv; i_cmp_op = v.cmp; i_cmp_sign = v.sgn;
      end else if (noise && k == 2) begin
        i_alu_op = ~v.op; i_rhs_inv = ~v.inv; i_cmp_op = ~v.cmp; i_cmp_sign = ~v.sgn;
      end
      i_lhs = l[k*4 +: 4];
      i_rhs = h[k*4 +: 4];
    end
  endtask

  task automatic run_one(input vec_t v);
    drive_op(v, 1'b0, v, 1'b0);
    @(negedge clk);
    end_op(v);
    i_start = 1'b0;
  endtask

  initial begin
    set_vec(0,  2'd0, 1'b0, 2'd0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
    set_vec(1,  2'd0, 1'b1, 2'd2, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1);
    set_vec(2,  2'd0, 1'b1, 2'd3, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    set_vec(3,  2'd0, 1'b0, 2'd2, 1'b1, 16'h8000, 16'h0001, 16'h8001, 1'b0, 1'b1);
    set_vec(4,  2'd0, 1'b0, 2'd2, 1'b0, 16'h8000, 16'h0001, 16'h8001, 1'b0, 1'b0);
    set_vec(5,  2'd1, 1'b0, 2'd3, 1'b1, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0, 1'b1);
    set_vec(6,  2'd3, 1'b0, 2'd0, 1'b0, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0);
    set_vec(7,  2'd2, 1'b0, 2'd0, 1'b0, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b1);
    set_vec(8,  2'd2, 1'b0, 2'd0, 1'b0, 16'h1234, 16'h1334, 16'h1334, 1'b0, 1'b0);
    set_vec(9,  2'd0, 1'b0, 2'd1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    set_vec(10, 2'd0, 1'b1, 2'd2, 1'b0, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);
    set_vec(11, 2'd0, 1'b1, 2'd2, 1'b1, 16'h7FFF, 16'h8000, 16'hFFFF, 1'b0, 1'b0);
    set_vec(12, 2'd2, 1'b1, 2'd2, 1'b0, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
    set_vec(13, 2'd3, 1'b1, 2'd3, 1'b1, 16'h00F0, 16'h0F0F, 16'hF000, 1'b0, 1'b0);

    #1;
    chk("rst_res", {28'd0, o_res}, 32'd0);
    chk("rst_vld", {31'd0, o_res_vld}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_cmp", {30'd0, o_cmp, o_cout}, 32'd0);
    chk("rst_cmp_vld", {31'd0, o_cmp_vld}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < 14; i++) run_one(vt[i]);

    // Outputs hold between operations.
    run_one(vt[9]);
    @(negedge clk);
    @(negedge clk);
    chk("hold_vld", {31'd0, o_res_vld}, 32'd0);
    chk("hold_res", {28'd0, o_res}, 32'd0);
    chk("hold_cmp", {30'd0, o_cmp, o_cout}, 32'd3);
    chk("hold_cmp_vld", {31'd0, o_cmp_vld}, 32'd0);
    chk("hold_busy", {31'd0, o_busy}, 32'd0);

    // Back-to-back with a stray start in the second operation.
    drive_op(vt[1], 1'b0, vt[1], 1'b0);
    drive_op(vt[6], 1'b1, vt[1], 1'b1);
    @(negedge clk);
    end_op(vt[6]);
    i_start = 1'b0;
    @(negedge clk);
    chk("b2b_vld_off", {31'd0, o_res_vld}, 32'd0);

    // Reset in the middle of an operation.
    for (int unsigned k = 0; k < 2; k++) begin
      @(negedge clk);
      i_start = (k == 0); i_alu_op = 2'd0; i_rhs_inv = 1'b0; i_cmp_op = 2'd1;
      i_lhs = 4'hF; i_rhs = 4'h1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_res", {28'd0, o_res}, 32'd0);
    chk("mrst_vld", {31'd0, o_res_vld}, 32'd0);
    chk("mrst_busy", {31'd0, o_busy}, 32'd0);
    chk("mrst_cmp", {30'd0, o_cmp, o_cout}, 32'd0);
    chk("mrst_cmp_vld", {31'd0, o_cmp_vld}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    i_start = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", {30'd0, o_cmp_vld, o_res_vld}, 32'd0);
    end
    run_one(vt[3]);
    run_one(vt[0]);

    // 8-bit slice instance: 0xFFFFFFFF + 1.
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("w_res", {24'd0, w_res}, 32'd0);
        chk("w_vld", {31'd0, w_res_vld}, 32'd1);
        chk("w_busy", {31'd0, w_busy}, 32'd1);
      end
      w_start = (k == 0);
      w_lhs = 8'hFF;
      w_rhs = (k == 0) ? 8'h01 : 8'h00;
    end
    @(negedge clk);
    w_start = 1'b0;
    chk("w_last_res", {24'd0, w_res}, 32'd0);
    chk("w_cmp_vld", {31'd0, w_cmp_vld}, 32'd1);
    chk("w_cout", {31'd0, w_cout}, 32'd1);
    chk("w_cmp", {31'd0, w_cmp}, 32'd0);
    @(negedge clk);
    chk("w_cmp_vld_off", {31'd0, w_cmp_vld}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
